// File: rtl/audio_sram_arbiter.sv
// Arbiter sharing one 1M x 16 asynchronous SRAM between the recorder (writes) and the player (reads).
// Round-robin grant, fixed-length strobe timing and a turnaround cycle after every access.
module audio_sram_arbiter #(
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned RD_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rec_req,
    input  logic [19:0] i_rec_addr,
    input  logic [15:0] i_rec_data,
    output logic        o_rec_ack,
    input  logic        i_play_req,
    input  logic [19:0] i_play_addr,
    output logic [15:0] o_play_data,
    output logic        o_play_valid,
    output logic        o_busy,
    output logic [19:0] o_sram_addr,
    inout  wire  [15:0] io_sram_dq,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_ce_n,
    output logic        o_sram_lb_n,
    output logic        o_sram_ub_n
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RECOV} state_e;
    typedef enum logic {REC, PLAY} grant_e;

    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] play_data_q, play_data_d;
    logic        rec_ack_q, rec_ack_d;
    logic        play_valid_q, play_valid_d;
    logic        busy_q, busy_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        ce_n_q, ce_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic        grant_rec;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sram_addr_d  = sram_addr_q;
        wr_data_d    = wr_data_q;
        play_data_d  = play_data_q;
        rec_ack_d    = 1'b0;
        play_valid_d = 1'b0;
        grant_rec    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rec_req || i_play_req) begin
                    // On a tie the requester that was not served last wins.
                    grant_rec = i_rec_req && (!i_play_req || last_grant_q == PLAY);
                    if (grant_rec) begin
                        state_d      = S_WRITE;
                        cnt_d        = WR_LOAD;
                        last_grant_d = REC;
                        sram_addr_d  = i_rec_addr;
                        wr_data_d    = i_rec_data;
                    end else begin
                        state_d      = S_READ;
                        cnt_d        = RD_LOAD;
                        last_grant_d = PLAY;
                        sram_addr_d  = i_play_addr;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_RECOV;
                    rec_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RECOV;
                    play_valid_d = 1'b1;
                    play_data_d  = io_sram_dq;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // SRAM strobes are decoded from the next state so they leave the chip as flop outputs.
        busy_d  = (state_d != S_IDLE);
        ce_n_d  = (state_d == S_IDLE);
        we_n_d  = (state_d != S_WRITE);
        oe_n_d  = (state_d != S_READ);
        dq_oe_d = (state_d == S_WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= REC;
            cnt_q        <= 4'd0;
            sram_addr_q  <= 20'd0;
            wr_data_q    <= 16'd0;
            play_data_q  <= 16'd0;
            rec_ack_q    <= 1'b0;
            play_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            ce_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sram_addr_q  <= sram_addr_d;
            wr_data_q    <= wr_data_d;
            play_data_q  <= play_data_d;
            rec_ack_q    <= rec_ack_d;
            play_valid_q <= play_valid_d;
            busy_q       <= busy_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            ce_n_q       <= ce_n_d;
            dq_oe_q      <= dq_oe_d;
        end
    end

    assign io_sram_dq   = dq_oe_q ? wr_data_q : {16{1'bz}};
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_lb_n  = 1'b0;
    assign o_sram_ub_n  = 1'b0;
    assign o_rec_ack    = rec_ack_q;
    assign o_play_valid = play_valid_q;
    assign o_play_data  = play_data_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_audio_sram_arbiter.sv
// Self-checking bench for audio_sram_arbiter: behavioural SRAM, requester drivers and an in-order scoreboard.
module tb_audio_sram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_rec_req = 1'b0;
    logic [19:0] i_rec_addr = '0;
    logic [15:0] i_rec_data = '0;
    logic        o_rec_ack;
    logic        i_play_req = 1'b0;
    logic [19:0] i_play_addr = '0;
    logic [15:0] o_play_data;
    logic        o_play_valid;
    logic        o_busy;
    logic [19:0] o_sram_addr;
    wire  [15:0] io_sram_dq;
    logic        o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;

    typedef struct packed {
        logic        is_wr;
        logic [19:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        mon_t;
    int          checks = 0;
    int          errors = 0;
    int          overlap_cnt = 0;
    int          oe_low_cnt = 0;
    int          rec_ack_cnt = 0;
    int          ack_before;
    logic [19:0] rd_addr_seen = '0;
    logic [15:0] mem [logic [19:0]];
    logic [15:0] sram_rd = '0;

    audio_sram_arbiter #(.WR_CYCLES(2), .RD_CYCLES(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rec_req(i_rec_req), .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data), .o_rec_ack(o_rec_ack),
        .i_play_req(i_play_req), .i_play_addr(i_play_addr), .o_play_data(o_play_data),
        .o_play_valid(o_play_valid), .o_busy(o_busy),
        .o_sram_addr(o_sram_addr), .io_sram_dq(io_sram_dq),
        .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_ce_n(o_sram_ce_n),
        .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural asynchronous SRAM.
    always @(posedge i_clk)
        if (!o_sram_ce_n && !o_sram_we_n) mem[o_sram_addr] = io_sram_dq;
    always @(negedge i_clk)
        sram_rd = mem.exists(o_sram_addr) ? mem[o_sram_addr] : 16'h0000;
    assign io_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? sram_rd : {16{1'bz}};

    // Monitor: checks bus cycles against the scoreboard head and pops on each ack/valid.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (!o_sram_we_n && !o_sram_oe_n) overlap_cnt++;
            if (!o_sram_oe_n) begin
                oe_low_cnt++;
                rd_addr_seen = o_sram_addr;
            end
            if (!o_sram_we_n) begin
                if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    check("wr_addr", o_sram_addr, exp_q[0].addr);
                    check("wr_dq", io_sram_dq, exp_q[0].data);
                end
            end
            if (o_rec_ack || o_play_valid) begin
                if (o_rec_ack) rec_ack_cnt++;
                check("recov_ctl", {o_sram_we_n, o_sram_oe_n, o_sram_ce_n, dut.dq_oe_q, o_busy}, 5'b11001);
                check("ack_valid_excl", o_rec_ack & o_play_valid, 0);
                if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
                else begin
                    mon_t = exp_q.pop_front();
                    check("grant_kind", o_rec_ack, mon_t.is_wr);
                    if (!mon_t.is_wr) begin
                        check("rd_addr", rd_addr_seen, mon_t.addr);
                        check("rd_data", o_play_data, mon_t.data);
                    end
                end
            end
        end
    end

    task automatic rec_txn(input logic [19:0] a, input logic [15:0] d);
        bit seen = 1'b0;
        i_rec_addr = a;
        i_rec_data = d;
        i_rec_req  = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge i_clk);
            seen = o_rec_ack;
        end
        if (!seen) check("rec_timeout", 0, 1);
        @(posedge i_clk);
        #1 i_rec_req = 1'b0;
    endtask

    task automatic play_txn(input logic [19:0] a);
        bit seen = 1'b0;
        i_play_addr = a;
        i_play_req  = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge i_clk);
            seen = o_play_valid;
        end
        if (!seen) check("play_timeout", 0, 1);
        @(posedge i_clk);
        #1 i_play_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_outs", {o_rec_ack, o_play_valid, o_busy, o_sram_we_n, o_sram_oe_n, o_sram_ce_n,
                           o_sram_lb_n, o_sram_ub_n, dut.dq_oe_q}, 9'b000111000);
        check("rst_addr_data", {o_sram_addr, o_play_data}, 36'h0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_after_rst", {o_busy, o_sram_ce_n}, 2'b01);

        // Simultaneous held requests right after reset: PLAY, REC, PLAY, REC.
        mem[20'h00100] = 16'h1111;
        mem[20'h00101] = 16'h2222;
        exp_q.push_back('{is_wr: 1'b0, addr: 20'h00100, data: 16'h1111});
        exp_q.push_back('{is_wr: 1'b1, addr: 20'h00200, data: 16'hAAAA});
        exp_q.push_back('{is_wr: 1'b0, addr: 20'h00101, data: 16'h2222});
        exp_q.push_back('{is_wr: 1'b1, addr: 20'h00201, data: 16'hBBBB});
        fork
            begin play_txn(20'h00100); play_txn(20'h00101); end
            begin rec_txn(20'h00200, 16'hAAAA); rec_txn(20'h00201, 16'hBBBB); end
        join
        check("mem_200", mem[20'h00200], 16'hAAAA);
        check("mem_201", mem[20'h00201], 16'hBBBB);

        // Single read: strobe length and data hold after req drops.
        mem[20'h00010] = 16'h1234;
        exp_q.push_back('{is_wr: 1'b0, addr: 20'h00010, data: 16'h1234});
        @(negedge i_clk);
        oe_low_cnt = 0;
        play_txn(20'h00010);
        repeat (3) @(negedge i_clk);
        check("rd_oe_cycles", oe_low_cnt, 2);
        check("rd_hold", o_play_data, 16'h1234);

        // Single write with cycle-by-cycle strobe timing (cycle 1 = grant cycle).
        exp_q.push_back('{is_wr: 1'b1, addr: 20'h00010, data: 16'hA5A5});
        @(negedge i_clk);
        i_rec_addr = 20'h00010;
        i_rec_data = 16'hA5A5;
        i_rec_req  = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge i_clk);
            check($sformatf("wr_cyc%0d", k), {o_sram_we_n, o_busy, o_sram_ce_n, o_rec_ack},
                  {(k < 2 || k > 3), (k >= 2 && k <= 4), !(k >= 2 && k <= 4), (k == 4)});
            if (k == 4) begin
                @(posedge i_clk);
                #1 i_rec_req = 1'b0;
            end
        end
        check("mem_10", mem[20'h00010], 16'hA5A5);

        // Reset during the second we_n-low cycle; held request is served after release.
        exp_q.push_back('{is_wr: 1'b1, addr: 20'h00300, data: 16'h5555});
        @(negedge i_clk);
        i_rec_addr = 20'h00300;
        i_rec_data = 16'h5555;
        i_rec_req  = 1'b1;
        repeat (2) @(negedge i_clk);
        check("pre_rst_we", o_sram_we_n, 0);
        ack_before = rec_ack_cnt;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {o_sram_we_n, o_sram_oe_n, o_sram_ce_n, dut.dq_oe_q, o_busy, o_rec_ack}, 6'b111000);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rec_txn(20'h00300, 16'h5555);
        check("rst_ack_once", rec_ack_cnt - ack_before, 1);
        check("mem_300", mem[20'h00300], 16'h5555);

        // Top address passes through unchanged.
        exp_q.push_back('{is_wr: 1'b1, addr: 20'hFFFFF, data: 16'hBEEF});
        rec_txn(20'hFFFFF, 16'hBEEF);
        exp_q.push_back('{is_wr: 1'b0, addr: 20'hFFFFF, data: 16'hBEEF});
        play_txn(20'hFFFFF);
        check("play_beef", o_play_data, 16'hBEEF);

        // Write data changed one cycle after grant must not reach the SRAM.
        exp_q.push_back('{is_wr: 1'b1, addr: 20'h00020, data: 16'h0001});
        @(negedge i_clk);
        fork
            rec_txn(20'h00020, 16'h0001);
            begin
                @(posedge i_clk);
                @(posedge i_clk);
                #1 i_rec_data = 16'h0002;
            end
        join
        check("mem_20", mem[20'h00020], 16'h0001);

        repeat (3) @(negedge i_clk);
        check("we_oe_overlap", overlap_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
